// File: rtl/interp_ctrl_pkg.sv
// Shared definitions for the interpolator sequencer: FSM encoding and gain field widths.
package interp_ctrl_pkg;

  localparam int unsigned EXP_W           = 5;
  localparam int unsigned MAN_W           = 18;
  localparam int unsigned GAIN_W          = EXP_W + MAN_W;
  localparam int unsigned RATIO_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  typedef struct packed {
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } gain_t;

endpackage

// File: rtl/interp_ctrl_cfg_sync_stable.sv
// Two-flop synchronizer for a quasi-static register bus plus a stability qualifier
// that only flags the bus once it has held one value for STABLE_CYCLES clocks.
module cfg_sync_stable #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_cfg,
  output logic             stable
);

  localparam int unsigned       CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] meta_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter restarts on the same edge that sync_cfg takes a new value.
  always_comb begin
    cnt_d = cnt_q;
    if (meta_q != sync_cfg) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      sync_cfg <= '0;
      cnt_q    <= '0;
      stable   <= 1'b0;
    end else begin
      meta_q   <= din;
      sync_cfg <= meta_q;
      cnt_q    <= cnt_d;
      stable   <= (cnt_d == CNT_MAX);
    end
  end

endmodule

// File: rtl/interp_ctrl.sv
// Interpolator sequencer: qualifies the asynchronous gain/ratio configuration, applies it
// atomically at a frame boundary and generates the phase index and input-sample request.
module interp_ctrl
  import interp_ctrl_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH   = RATIO_W_DEFAULT,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clkEn,
  input  logic [EXP_W-1:0]       cfgExponent,
  input  logic [MAN_W-1:0]       cfgMantissa,
  input  logic [RATIO_WIDTH-1:0] cfgRatio,
  output logic [EXP_W-1:0]       exponent,
  output logic [MAN_W-1:0]       mantissa,
  output logic [RATIO_WIDTH-1:0] ratio,
  output logic [RATIO_WIDTH-1:0] phase,
  output logic                   inputReq,
  output logic                   cfgUpdate,
  output logic                   pending
);

  localparam int unsigned CFG_W = GAIN_W + RATIO_WIDTH;

  logic [CFG_W-1:0]       cfg_bus;
  logic [CFG_W-1:0]       sync_cfg;
  logic                   stable;
  logic [CFG_W-1:0]       active_cfg;
  logic                   accept_c;
  logic                   wrap_c;

  gain_t                  hold_gain;
  logic [RATIO_WIDTH-1:0] hold_ratio;

  state_e                 state_q;
  state_e                 state_d;

  logic [EXP_W-1:0]       exponent_d;
  logic [MAN_W-1:0]       mantissa_d;
  logic [RATIO_WIDTH-1:0] ratio_d;
  logic [RATIO_WIDTH-1:0] phase_d;
  logic                   input_req_d;
  logic                   cfg_update_d;
  logic                   pending_d;

  assign cfg_bus    = {cfgExponent, cfgMantissa, cfgRatio};
  assign active_cfg = {exponent, mantissa, ratio};
  assign accept_c   = stable && (sync_cfg != active_cfg);
  assign wrap_c     = (phase == (ratio - RATIO_WIDTH'(1)));

  cfg_sync_stable #(
    .WIDTH         (CFG_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (cfg_bus),
    .sync_cfg (sync_cfg),
    .stable   (stable)
  );

  // Snapshot of the latest accepted value, so LOAD never sees a bus that is mid-change.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_gain  <= '0;
      hold_ratio <= '0;
    end else if (accept_c) begin
      hold_gain  <= sync_cfg[CFG_W-1:RATIO_WIDTH];
      hold_ratio <= sync_cfg[RATIO_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (pending) state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (clkEn && wrap_c && pending) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = (hold_ratio != '0) ? ST_RUN : ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Next values for the registered outputs; clkEn is ignored outside RUN.
  always_comb begin
    exponent_d   = exponent;
    mantissa_d   = mantissa;
    ratio_d      = ratio;
    phase_d      = phase;
    input_req_d  = 1'b0;
    cfg_update_d = 1'b0;
    pending_d    = accept_c && (state_q != ST_LOAD);
    case (state_q)
      ST_HALT: begin
        phase_d = '0;
      end
      ST_RUN: begin
        if (clkEn) begin
          input_req_d = (phase == '0);
          phase_d     = wrap_c ? '0 : phase + RATIO_WIDTH'(1);
        end
      end
      ST_LOAD: begin
        exponent_d   = hold_gain.exponent;
        mantissa_d   = hold_gain.mantissa;
        ratio_d      = hold_ratio;
        phase_d      = '0;
        cfg_update_d = 1'b1;
        pending_d    = 1'b0;
      end
      default: begin
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exponent  <= '0;
      mantissa  <= '0;
      ratio     <= '0;
      phase     <= '0;
      inputReq  <= 1'b0;
      cfgUpdate <= 1'b0;
      pending   <= 1'b0;
    end else begin
      exponent  <= exponent_d;
      mantissa  <= mantissa_d;
      ratio     <= ratio_d;
      phase     <= phase_d;
      inputReq  <= input_req_d;
      cfgUpdate <= cfg_update_d;
      pending   <= pending_d;
    end
  end

endmodule

// File: tb/tb_interp_ctrl.sv
// Self-checking bench for interp_ctrl: table of start-up configurations plus
// hand-written frame, boundary, glitch, reset and halt sequences against a cycle model.
module tb_interp_ctrl;
  import interp_ctrl_pkg::*;

  localparam int unsigned RW       = 16;
  localparam int unsigned SC       = 4;
  localparam int          PEND_LAT = 2 + SC + 1;
  localparam int          INF      = 32'h3fffffff;

  logic          clk;
  logic          reset;
  logic          clkEn;
  logic [4:0]    cfgExponent;
  logic [17:0]   cfgMantissa;
  logic [RW-1:0] cfgRatio;
  logic [4:0]    exponent;
  logic [17:0]   mantissa;
  logic [RW-1:0] ratio;
  logic [RW-1:0] phase;
  logic          inputReq;
  logic          cfgUpdate;
  logic          pending;

  interp_ctrl #(.RATIO_WIDTH(RW), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .clkEn       (clkEn),
    .cfgExponent (cfgExponent),
    .cfgMantissa (cfgMantissa),
    .cfgRatio    (cfgRatio),
    .exponent    (exponent),
    .mantissa    (mantissa),
    .ratio       (ratio),
    .phase       (phase),
    .inputReq    (inputReq),
    .cfgUpdate   (cfgUpdate),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cnt_req = 0;
  int cnt_upd = 0;

  // Cycle model: 0 = HALT, 1 = RUN, 2 = LOAD
  int            m_state = 0;
  logic [RW-1:0] m_phase = '0;
  logic [4:0]    m_exp   = '0;
  logic [17:0]   m_man   = '0;
  logic [RW-1:0] m_ratio = '0;
  logic          m_pend  = 1'b0;
  int            m_pend_at = INF;
  logic [4:0]    c_exp   = '0;
  logic [17:0]   c_man   = '0;
  logic [RW-1:0] c_ratio = '0;

  typedef struct {
    logic [RW-1:0] phase;
    logic          req;
    logic          upd;
    logic          pend;
    logic [4:0]    e;
    logic [17:0]   m;
    logic [RW-1:0] r;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0]    e;
    logic [17:0]   m;
    logic [RW-1:0] r;
    logic          upd;
    int            lat;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic step(input logic en);
    exp_t e;
    int   old;
    clkEn  = en;
    old    = m_state;
    e.req  = 1'b0;
    e.upd  = 1'b0;
    if (reset) begin
      m_state = 0; m_phase = '0; m_exp = '0; m_man = '0; m_ratio = '0;
      m_pend  = 1'b0; m_pend_at = INF;
    end else begin
      case (old)
        0: begin
          m_phase = '0;
          if (m_pend) m_state = 2;
        end
        1: begin
          if (en) begin
            e.req = (m_phase == '0);
            if (m_phase == m_ratio - RW'(1)) begin
              m_phase = '0;
              if (m_pend) m_state = 2;
            end else begin
              m_phase = m_phase + RW'(1);
            end
          end
        end
        default: begin
          m_exp = c_exp; m_man = c_man; m_ratio = c_ratio;
          m_phase = '0; e.upd = 1'b1;
          m_state = (c_ratio != '0) ? 1 : 0;
          m_pend_at = INF;
        end
      endcase
      m_pend = (old != 2) && (cyc + 1 >= m_pend_at);
    end
    e.phase = m_phase; e.pend = m_pend; e.e = m_exp; e.m = m_man; e.r = m_ratio;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("phase", 32'(phase), 32'(e.phase));
    chk("inputReq", 32'(inputReq), 32'(e.req));
    chk("cfgUpdate", 32'(cfgUpdate), 32'(e.upd));
    chk("pending", 32'(pending), 32'(e.pend));
    chk("exponent", 32'(exponent), 32'(e.e));
    chk("mantissa", 32'(mantissa), 32'(e.m));
    chk("ratio", 32'(ratio), 32'(e.r));
    if (inputReq === 1'b1) cnt_req++;
    if (cfgUpdate === 1'b1) cnt_upd++;
    clkEn = 1'b0;
  endtask

  task automatic set_cfg(input logic [4:0] e, input logic [17:0] m, input logic [RW-1:0] r);
    cfgExponent = e; cfgMantissa = m; cfgRatio = r;
    c_exp = e; c_man = m; c_ratio = r;
    if ({e, m, r} != {m_exp, m_man, m_ratio}) m_pend_at = cyc + PEND_LAT;
    else m_pend_at = INF;
  endtask

  task automatic do_reset(input logic [4:0] e, input logic [17:0] m, input logic [RW-1:0] r);
    reset = 1'b1;
    cfgExponent = e; cfgMantissa = m; cfgRatio = r;
    c_exp = e; c_man = m; c_ratio = r;
    step(1'b1);
    step(1'b0);
    reset = 1'b0;
    set_cfg(e, m, r);
  endtask

  task automatic run_pattern(input int n);
    for (int k = 0; k < n; k++) step(cyc % 3 == 0);
  endtask

  initial begin
    int lat;
    int found;
    reset = 1'b1; clkEn = 1'b0;
    cfgExponent = '0; cfgMantissa = '0; cfgRatio = '0;

    tbl[0] = '{e: 5'd0,  m: 18'h00000, r: 16'd0,      upd: 1'b0, lat: -1};
    tbl[1] = '{e: 5'd3,  m: 18'h10000, r: 16'd4,      upd: 1'b1, lat: PEND_LAT};
    tbl[2] = '{e: 5'd31, m: 18'h3FFFF, r: 16'd1,      upd: 1'b1, lat: PEND_LAT};
    tbl[3] = '{e: 5'd5,  m: 18'h0ABCD, r: 16'hFFFF,   upd: 1'b1, lat: PEND_LAT};
    tbl[4] = '{e: 5'd7,  m: 18'h12345, r: 16'd0,      upd: 1'b1, lat: PEND_LAT};

    // Start-up from reset with each configuration, clkEn toggling throughout
    for (int i = 0; i < 5; i++) begin
      do_reset(tbl[i].e, tbl[i].m, tbl[i].r);
      cnt_upd = 0; lat = -1;
      for (int k = 1; k <= 14; k++) begin
        step(k[0]);
        if (pending === 1'b1 && lat < 0) lat = k;
      end
      chk("tbl_update_count", 32'(cnt_upd), 32'(tbl[i].upd));
      chk("tbl_pend_latency", 32'(lat), 32'(tbl[i].lat));
      chk("tbl_exponent", 32'(exponent), tbl[i].upd ? 32'(tbl[i].e) : 32'd0);
      chk("tbl_mantissa", 32'(mantissa), tbl[i].upd ? 32'(tbl[i].m) : 32'd0);
      chk("tbl_ratio", 32'(ratio), tbl[i].upd ? 32'(tbl[i].r) : 32'd0);
    end

    // Frame timing: ratio 4, clkEn every 3 clocks
    do_reset(5'd3, 18'h10000, 16'd4);
    for (int k = 0; k < 10; k++) step(1'b0);
    chk("start_ratio", 32'(ratio), 32'd4);
    cnt_req = 0;
    while (cyc % 3 != 0) step(1'b0);
    run_pattern(36);
    chk("frame_req_count", 32'(cnt_req), 32'd3);

    // Boundary apply: ratio 4 -> 2 requested at phase 1
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      run_pattern(1);
      if (m_state == 1 && m_phase == 16'd1 && cyc % 3 == 1) found = 1;
    end
    chk("boundary_reach_phase1", 32'(found), 32'd1);
    chk("boundary_phase_now", 32'(phase), 32'd1);
    set_cfg(5'd3, 18'h10000, 16'd2);
    cnt_upd = 0;
    run_pattern(30);
    chk("boundary_update_count", 32'(cnt_upd), 32'd1);
    chk("boundary_ratio", 32'(ratio), 32'd2);

    // Halt from run at the frame boundary
    set_cfg(5'd3, 18'h10000, 16'd0);
    run_pattern(24);
    chk("halt_ratio", 32'(ratio), 32'd0);
    cnt_req = 0;
    run_pattern(15);
    chk("halt_req_silent", 32'(cnt_req), 32'd0);
    chk("halt_phase", 32'(phase), 32'd0);

    // Glitch rejection: mantissa toggling every 2 clocks must never be applied
    do_reset(5'd0, 18'h0, 16'd0);
    cnt_upd = 0;
    for (int i = 0; i < 10; i++) begin
      set_cfg(5'd0, i[0] ? 18'h22222 : 18'h11111, 16'd0);
      step(1'b0);
      step(1'b0);
      chk("glitch_no_pending", 32'(pending), 32'd0);
    end
    set_cfg(5'd0, 18'h0ABCD, 16'd0);
    for (int k = 0; k < 12; k++) step(1'b0);
    chk("glitch_update_count", 32'(cnt_upd), 32'd1);
    chk("glitch_mantissa", 32'(mantissa), 32'h0ABCD);

    // Reset during the LOAD cycle wins
    do_reset(5'd0, 18'h0, 16'd0);
    set_cfg(5'd9, 18'h15555, 16'd3);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step(1'b0);
      if (m_state == 2) found = 1;
    end
    chk("reach_load", 32'(found), 32'd1);
    cnt_upd = 0;
    reset = 1'b1;
    cfgExponent = '0; cfgMantissa = '0; cfgRatio = '0;
    c_exp = '0; c_man = '0; c_ratio = '0;
    step(1'b1);
    chk("rst_load_ratio", 32'(ratio), 32'd0);
    chk("rst_load_exponent", 32'(exponent), 32'd0);
    step(1'b0);
    reset = 1'b0;
    set_cfg(5'd0, 18'h0, 16'd0);
    for (int k = 0; k < 10; k++) step(1'b1);
    chk("rst_load_no_update", 32'(cnt_upd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
